// File: rtl/counter_checker_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : counter_checker_if                                           |
// | Description : Sample stream and status bundle for counter_checker.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface counter_checker_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             overflow_in;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [15:0]      err_count;
    logic [15:0]      wrap_count;

    modport master (
        output en, count_in, overflow_in, clr,
        input  locked, err_pulse, err_count, wrap_count
    );

    modport slave (
        input  en, count_in, overflow_in, clr,
        output locked, err_pulse, err_count, wrap_count
    );
endinterface
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : counter_checker                                              |
// | Description : Locks onto a +1 count stream and flags broken samples.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module counter_checker #(
    parameter int WIDTH     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_checker_if.slave  bus
);
    localparam logic [1:0]       S_UNLOCKED  = 2'd0;
    localparam logic [1:0]       S_ACQUIRE   = 2'd1;
    localparam logic [1:0]       S_LOCKED    = 2'd2;
    localparam logic [3:0]       C_LOCK_CNT  = 4'(LOCK_CNT);
    localparam logic [3:0]       C_ERR_LIMIT = 4'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
    localparam logic [15:0]      C_SAT       = 16'hFFFF;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_exp;
    logic [3:0]       r_run;
    logic [3:0]       r_miss;
    logic             r_err_pulse;
    logic [15:0]      r_err_count;
    logic [15:0]      r_wrap_count;

    logic             w_ov_ok;
    logic             w_match;
    logic [3:0]       w_run_inc;
    logic [3:0]       w_miss_inc;
    logic             w_err;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    assign w_ov_ok    = (bus.overflow_in == (bus.count_in == {WIDTH{1'b1}}));
    assign w_match    = (bus.count_in == r_exp) && w_ov_ok;
    assign w_run_inc  = r_run + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;
    assign w_next     = bus.count_in + C_ONE;
    assign w_err      = bus.en && (r_state == S_LOCKED) && !w_match;
    // A matched sample of zero can only follow all-ones, so it proves a wrap.
    assign w_wrap     = bus.en && (r_state == S_LOCKED) && w_match && (r_exp == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_UNLOCKED;
            r_exp   <= '0;
            r_run   <= 4'd0;
            r_miss  <= 4'd0;
        end else if (bus.en) begin
            case (r_state)
                S_UNLOCKED: begin
                    if (w_ov_ok) begin
                        r_exp   <= w_next;
                        r_run   <= 4'd1;
                        r_state <= S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    if (!w_ov_ok) begin
                        r_run   <= 4'd0;
                        r_state <= S_UNLOCKED;
                    end else if (w_match) begin
                        r_exp <= w_next;
                        r_run <= w_run_inc;
                        if (w_run_inc == C_LOCK_CNT) begin
                            r_miss  <= 4'd0;
                            r_state <= S_LOCKED;
                        end
                    end else begin
                        r_exp <= w_next;
                        r_run <= 4'd1;
                    end
                end
                S_LOCKED: begin
                    r_exp <= w_next;
                    if (w_match) begin
                        r_miss <= 4'd0;
                    end else if (w_miss_inc == C_ERR_LIMIT) begin
                        r_run   <= 4'd0;
                        r_miss  <= 4'd0;
                        r_state <= S_UNLOCKED;
                    end else begin
                        r_miss <= w_miss_inc;
                    end
                end
                default: begin
                    r_state <= S_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse  <= 1'b0;
            r_err_count  <= 16'd0;
            r_wrap_count <= 16'd0;
        end else begin
            r_err_pulse <= w_err;
            if (bus.clr) begin
                r_err_count  <= 16'd0;
                r_wrap_count <= 16'd0;
            end else begin
                if (w_err && (r_err_count != C_SAT)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (w_wrap && (r_wrap_count != C_SAT)) begin
                    r_wrap_count <= r_wrap_count + 16'd1;
                end
            end
        end
    end

    assign bus.locked     = (r_state == S_LOCKED);
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;
    assign bus.wrap_count = r_wrap_count;
endmodule
`default_nettype wire
